// File: rtl/dpram_fifo_ctrl.sv
// FIFO pointer, occupancy and flag controller for an external dual-port async-read RAM.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign wr_acc = wr_en & ~full & ~rst;
  assign rd_acc = rd_en & ~empty;

  // RAM drive: port A writes, port B is read-only.
  assign ram_we_a   = wr_acc;
  assign ram_addr_a = wr_ptr[ADDR_W-1:0];
  assign ram_din_a  = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr[ADDR_W-1:0];
  assign ram_din_b  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= ram_dout_b;
      end
      rd_valid <= rd_acc;
      if (wr_acc && !rd_acc) begin
        count <= count + PTR_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - PTR_W'(1);
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: queue-based reference model plus directed literal checks.
module tb_dpram_fifo_ctrl;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_din_a;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_din_b;
  logic [DATA_W-1:0] ram_dout_b;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  // Dual-port RAM with combinational read, as seen by the controller.
  logic [DATA_W-1:0] mem [DEPTH];
  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
  always @(posedge clk) if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
  assign ram_dout_b = mem[ram_addr_b];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a queue of stored words plus counts of accepted pushes/pops.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data = '0;
  bit m_rd_valid = 0;
  int m_pushes = 0;
  int m_pops = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit armed = 0;
  bit was_full, was_empty;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 0; m_pushes = 0; m_pops = 0;
      m_ovf = 0; m_unf = 0; armed = 1;
    end else begin
      was_full  = (q.size() == int'(DEPTH));
      was_empty = (q.size() == 0);
      if (wr_en && was_full)  m_ovf = 1;
      if (rd_en && was_empty) m_unf = 1;
      m_rd_valid = 0;
      if (rd_en && !was_empty) begin
        m_rd_data = q.pop_front();
        m_rd_valid = 1;
        m_pops++;
      end
      if (wr_en && !was_full) begin
        q.push_back(wr_data);
        m_pushes++;
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      automatic bit exp_we = wr_en && (q.size() < int'(DEPTH)) && !rst;
      chk("cmp_empty",    32'(empty),      32'(q.size() == 0));
      chk("cmp_full",     32'(full),       32'(q.size() == int'(DEPTH)));
      chk("cmp_count",    32'(count),      32'(q.size()));
      chk("cmp_rd_valid", 32'(rd_valid),   32'(m_rd_valid));
      chk("cmp_rd_data",  32'(rd_data),    32'(m_rd_data));
      chk("cmp_we_a",     32'(ram_we_a),   32'(exp_we));
      chk("cmp_addr_a",   32'(ram_addr_a), 32'(m_pushes % int'(DEPTH)));
      chk("cmp_addr_b",   32'(ram_addr_b), 32'(m_pops % int'(DEPTH)));
      chk("cmp_we_b",     32'(ram_we_b),   32'(0));
      chk("cmp_din_b",    32'(ram_din_b),  32'(0));
      if (exp_we) chk("cmp_din_a", 32'(ram_din_a), 32'(wr_data));
`ifdef FIFO_ERR_FLAGS_EN
      chk("cmp_overflow",  32'(overflow),  32'(m_ovf));
      chk("cmp_underflow", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  task automatic drive(input bit w, input logic [7:0] d, input bit r);
    wr_en = w; wr_data = d; rd_en = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0);
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1; drive(0, 8'h00, 0);
    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    rst = 1; drive(1, 8'hAA, 0); #1;
    chk("rst_we_forced", 32'(ram_we_a), 0);
    tick(); rst = 0; drive(0, 8'h00, 0); tick();
    chk("rst_no_push", 32'(count), 0);

    // Two pushes, two pops
    drive(1, 8'hAA, 0); #1;
    chk("t2_addr0", 32'(ram_addr_a), 0);
    chk("t2_we0", 32'(ram_we_a), 1);
    tick();
    drive(1, 8'h55, 0); #1;
    chk("t2_addr1", 32'(ram_addr_a), 1);
    tick();
    drive(0, 8'h00, 1); tick();
    chk("t2_valid0", 32'(rd_valid), 1);
    chk("t2_data0", 32'(rd_data), 32'hAA);
    drive(0, 8'h00, 1); tick();
    chk("t2_valid1", 32'(rd_valid), 1);
    chk("t2_data1", 32'(rd_data), 32'h55);
    drive(0, 8'h00, 0); tick();
    chk("t2_valid_drop", 32'(rd_valid), 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_count", 32'(count), 0);

    // Fill, overflow attempt, drain
    do_reset();
    for (int i = 0; i < 16; i++) begin drive(1, 8'(i), 0); tick(); end
    chk("t3_full", 32'(full), 1);
    chk("t3_count16", 32'(count), 16);
    chk("t3_model_fill", 32'(q.size()), 16);
    drive(1, 8'hFF, 0); #1;
    chk("t3_we_blocked", 32'(ram_we_a), 0);
    tick();
    chk("t3_count_hold", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 1); tick();
      chk("t3_pop_data", 32'(rd_data), 32'(i));
    end
    drive(0, 8'h00, 0); tick();
    chk("t3_empty", 32'(empty), 1);

    // Wrap-around
    do_reset();
    for (int i = 0; i < 10; i++) begin drive(1, 8'(8'h40 + i), 0); tick(); end
    for (int i = 0; i < 10; i++) begin drive(0, 8'h00, 1); tick(); end
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h80 + i), 0); #1;
      chk("t4_wrap_addr", 32'(ram_addr_a), 32'((10 + i) % 16));
      tick();
    end
    drive(0, 8'h00, 0); tick();
    chk("t4_count10", 32'(count), 10);
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h00, 1); tick();
      chk("t4_pop_data", 32'(rd_data), 32'(8'h80 + i));
    end

    // Simultaneous push and pop
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 8'(i), 0); tick(); end
    drive(1, 8'h11, 1); tick();
    chk("t5_mid_count", 32'(count), 5);
    chk("t5_mid_valid", 32'(rd_valid), 1);
    do_reset();
    drive(1, 8'h22, 1); tick();
    chk("t5_empty_count", 32'(count), 1);
    chk("t5_empty_valid", 32'(rd_valid), 0);
    drive(0, 8'h00, 1); tick();
    chk("t5_empty_data", 32'(rd_data), 32'h22);
    do_reset();
    for (int i = 0; i < 16; i++) begin drive(1, 8'(8'h30 + i), 0); tick(); end
    drive(1, 8'hEE, 1); tick();
    chk("t5_full_count", 32'(count), 15);
    chk("t5_full_data", 32'(rd_data), 32'h30);
    for (int i = 1; i < 16; i++) begin
      drive(0, 8'h00, 1); tick();
      chk("t5_full_pop", 32'(rd_data), 32'(8'h30 + i));
    end
    drive(0, 8'h00, 0); tick();
    chk("t5_drained", 32'(empty), 1);

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags
    do_reset();
    drive(0, 8'h00, 1); tick();
    chk("t6_underflow", 32'(underflow), 1);
    for (int i = 0; i < 16; i++) begin drive(1, 8'(i), 0); tick(); end
    chk("t6_no_overflow_yet", 32'(overflow), 0);
    drive(1, 8'h99, 0); tick();
    chk("t6_overflow", 32'(overflow), 1);
    drive(0, 8'h00, 1); tick(); tick(); tick();
    chk("t6_ovf_sticky", 32'(overflow), 1);
    chk("t6_unf_sticky", 32'(underflow), 1);
    do_reset();
    chk("t6_ovf_clr", 32'(overflow), 0);
    chk("t6_unf_clr", 32'(underflow), 0);
`endif

    // Randomized traffic with phase-dependent push/pop bias and rare resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      automatic int phase = (c / 200) % 3;
      automatic int pw = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      automatic int pr = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
      tick();
    end
    rst = 0; drive(0, 8'h00, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
